lift_wrapper_input_unpacker: RTL and testbench
==============================================

Name: lift_wrapper_input_unpacker

Overview:
- Wide-to-narrow counterpart of the lift output buffer.
- Accepts one block of DEPTH packed words, each LANES coefficients of W bits, then streams them out one coefficient per handshake.
- Output order is address-major, lane-minor.
- Sits between the wide host/memory side and the serial lift datapath input, which consumes one coefficient plus its (lane, address) tag per cycle.

Parameters:
- W, 30, coefficient width in bits.
- LANES, 8, coefficients per packed word; lane k occupies in_data[W*k+W-1 : W*k].
- DEPTH, 64, packed words per block.
- AW, 6, address width; equals clog2(DEPTH).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse in IDLE begins a new block; ignored in all other states.
- in_data  input  LANES*W  packed word, lane 0 in LSBs.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept in_data this cycle.
- dout  output  W  current coefficient.
- dout_lane  output  3  lane index of dout.
- dout_addr  output  AW  word address of dout.
- dout_valid  output  1  dout/dout_lane/dout_addr valid.
- dout_ready  input  1  consumer accepts dout this cycle.
- busy  output  1  high in LOAD or STREAM.
- done  output  1  one-cycle pulse after the last coefficient is accepted.

Behaviour:
- Storage: DEPTH x (LANES*W) RAM, synchronous write, asynchronous read; contents not reset, no initial value.
- States: IDLE, LOAD, STREAM, DONE (state register, binary encoded).
- Reset (async, any state): state=IDLE, wr_ptr=0, rd_addr=0, rd_lane=0, in_ready=0, dout_valid=0, busy=0, done=0, dout_lane=0, dout_addr=0; dout is don't-care (RAM read).
- IDLE:
  - in_ready=0, dout_valid=0.
  - start=1 -> LOAD next cycle; wr_ptr, rd_addr and rd_lane cleared.
- LOAD:
  - in_ready=1 combinationally from state (no dependence on in_valid).
  - On in_valid&in_ready: RAM[wr_ptr] <= in_data, wr_ptr++.
  - Acceptance of word DEPTH-1 -> STREAM next cycle; in_ready=0 from that cycle on.
  - in_valid low holds the state indefinitely; partial blocks are never streamed.
- STREAM:
  - dout_valid=1; dout = RAM[rd_addr] lane rd_lane; dout_addr=rd_addr; dout_lane=rd_lane.
  - No combinational path from dout_ready to any output.
  - On dout_valid&dout_ready: rd_lane++; on rd_lane=LANES-1 it wraps to 0 and rd_addr++.
  - dout_ready low holds all outputs stable (standard valid/ready hold rule).
  - Acceptance of (addr DEPTH-1, lane LANES-1) -> DONE; dout_valid=0 the next cycle.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. A start in DONE is ignored.
- busy = state is LOAD or STREAM.
- Latency:
  - Coefficient (0,0) is valid the cycle after the last write.
  - Minimum block time is 1 (start) + DEPTH + DEPTH*LANES + 1 (DONE) cycles.
- Throughput: one coefficient per cycle with dout_ready held high; one word per cycle in LOAD.
- Reset mid-LOAD or mid-STREAM: block is abandoned, the next start restarts from address 0, and no done pulse is issued for the abandoned block.

Test Plan:
- Reset then idle: assert rst mid-cycle async -> in_ready=0, dout_valid=0, busy=0, done=0 immediately; in_valid=1 for 10 cycles with no start -> in_ready stays 0.
- Full block, no back-pressure: start, then 64 words with lane k of word a = a*8+k, dout_ready=1 -> 512 outputs dout=0..511 in order, dout_addr/dout_lane matching; done pulses exactly once, 513 cycles after the last write.
- Input gaps: same block with in_valid toggled 1,0,0,1,... -> in_ready high throughout LOAD, only words presented with in_valid=1 are stored, and the output sequence is identical to the no-gap case.
- Back-pressure: dout_ready randomly low 50% -> dout/dout_lane/dout_addr stable while dout_valid&!dout_ready, no loss or duplication, done after 512 accepted transfers.
- Lane/address wrap: check the transfer at addr 0 lane 7 -> next is addr 1 lane 0; check addr 63 lane 7 -> dout_valid drops next cycle and done=1.
- Reset mid-STREAM: assert rst after 100 coefficients -> state IDLE, no done; then start plus a new block with lane k of word a = 1000+a*8+k -> outputs begin at 1000, address 0.

Source files
------------

// File: rtl/lift_wrapper_input_unpacker.sv
`timescale 1ns/1ps
// Wide-to-narrow block unpacker for the lift datapath input.
// Loads DEPTH packed words of LANES coefficients, then streams them one per
// handshake in address-major, lane-minor order with a (lane, address) tag.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   start               pulse in IDLE to begin a block
//   in_data/in_valid    packed word input, lane 0 in LSBs
//   in_ready            high for the whole LOAD state
//   dout/dout_lane/dout_addr/dout_valid/dout_ready  coefficient stream
//   busy                LOAD or STREAM
//   done                one-cycle pulse after the last coefficient
module lift_wrapper_input_unpacker #(
  parameter int W     = 30,
  parameter int LANES = 8,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LANES*W-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [W-1:0]       dout,
  output logic [2:0]         dout_lane,
  output logic [AW-1:0]      dout_addr,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_addr;
  logic [2:0]         rd_lane;
  logic [LANES*W-1:0] mem [DEPTH];
  logic [LANES*W-1:0] rd_word;

  logic wr_en;
  logic rd_fire;
  logic last_word;
  logic last_lane;
  logic last_coef;

  assign wr_en     = in_valid & in_ready;
  assign rd_fire   = dout_valid & dout_ready;
  assign last_word = (wr_ptr == AW'(DEPTH-1));
  assign last_lane = (rd_lane == 3'(LANES-1));
  assign last_coef = last_lane & (rd_addr == AW'(DEPTH-1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (wr_en && last_word) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (rd_fire && last_coef) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs depend on state only, so dout_ready never reaches an output
  always_comb begin
    in_ready   = 1'b0;
    dout_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_STREAM: begin
        dout_valid = 1'b1;
        busy       = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Write pointer and read cursor
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_addr <= '0;
      rd_lane <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            wr_ptr  <= '0;
            rd_addr <= '0;
            rd_lane <= '0;
          end
        end
        S_LOAD: begin
          if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        end
        S_STREAM: begin
          if (rd_fire) begin
            if (last_lane) begin
              rd_lane <= '0;
              rd_addr <= rd_addr + 1'b1;
            end else begin
              rd_lane <= rd_lane + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Block RAM: synchronous write, asynchronous read, never reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  assign rd_word = mem[rd_addr];

  // Lane select by compare loop keeps index arithmetic out of part selects
  always_comb begin
    dout = '0;
    for (int k = 0; k < LANES; k++) begin
      if (rd_lane == 3'(k)) dout = rd_word[k*W +: W];
    end
  end

  assign dout_addr = rd_addr;
  assign dout_lane = rd_lane;

endmodule

// File: tb/tb_lift_wrapper_input_unpacker.sv
`timescale 1ns/1ps
// Self-checking bench for lift_wrapper_input_unpacker.
// Scenario table drives whole blocks against a queue-based coefficient model.
module tb_lift_wrapper_input_unpacker;

  localparam int W     = 30;
  localparam int LANES = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int N     = DEPTH * LANES;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [LANES*W-1:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [W-1:0]       dout;
  logic [2:0]         dout_lane;
  logic [AW-1:0]      dout_addr;
  logic               dout_valid;
  logic               dout_ready = 1'b0;
  logic               busy;
  logic               done;

  lift_wrapper_input_unpacker #(
    .W(W), .LANES(LANES), .DEPTH(DEPTH), .AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dout(dout),
    .dout_lane(dout_lane),
    .dout_addr(dout_addr),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int done_cnt = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  typedef struct {
    int base;
    bit rnd;
    bit gap;
    int bp;
    int abort_at;
    int exp_xfers;
    int exp_done;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails < 40)
        $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_block(input vec_t v);
    logic [W-1:0] q[$];
    logic [W-1:0] w;
    logic [W-1:0] pd;
    logic [AW-1:0] pa;
    logic [2:0] pl;
    bit stall;
    bit vv;
    int a, idx, t, c_last, d0;
    q.delete();
    d0 = done_cnt;
    c_last = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("load_entry_in_ready", in_ready, 1);
    chk("load_entry_busy", busy, 1);
    a = 0;
    t = 0;
    while (a < DEPTH && t < 2000) begin
      vv = v.gap ? (t % 3 == 0) : 1'b1;
      if (in_ready !== 1'b1) chk("load_in_ready", in_ready, 1);
      in_valid = vv;
      for (int k = 0; k < LANES; k++) begin
        w = v.rnd ? W'($urandom) : W'(v.base + a*LANES + k);
        if (!vv) w = W'($urandom);
        in_data[k*W +: W] = w;
        if (vv) q.push_back(w);
      end
      if (vv) begin
        c_last = cyc;
        a++;
      end
      t++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (a < DEPTH) chk("load_timeout", a, DEPTH);
    chk("stream_in_ready_low", in_ready, 0);
    chk("stream_first_valid", dout_valid, 1);
    idx = 0;
    t = 0;
    stall = 1'b0;
    pd = '0;
    pa = '0;
    pl = '0;
    while (idx < N && t < 20000) begin
      if (v.abort_at >= 0 && idx == v.abort_at) break;
      chk("dout_valid", dout_valid, 1);
      chk("dout", dout, q[idx]);
      chk("dout_addr", dout_addr, idx / LANES);
      chk("dout_lane", dout_lane, idx % LANES);
      if (stall) begin
        chk("hold_dout", dout, pd);
        chk("hold_addr", dout_addr, pa);
        chk("hold_lane", dout_lane, pl);
      end
      dout_ready = ($urandom_range(0, 99) >= v.bp);
      stall = !dout_ready;
      pd = dout;
      pa = dout_addr;
      pl = dout_lane;
      if (dout_ready) idx++;
      t++;
      @(negedge clk);
    end
    dout_ready = 1'b0;
    if (v.abort_at >= 0) begin
      chk("abort_xfers", idx, v.exp_xfers);
      #2 rst = 1'b1;
      #1;
      chk("abort_valid_low", dout_valid, 0);
      chk("abort_busy_low", busy, 0);
      chk("abort_done_low", done, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      chk("abort_no_done", done_cnt - d0, v.exp_done);
      chk("abort_idle_valid", dout_valid, 0);
    end else begin
      chk("stream_xfers", idx, v.exp_xfers);
      chk("done_pulse", done, 1);
      chk("done_valid_low", dout_valid, 0);
      chk("done_busy_low", busy, 0);
      if (v.bp == 0) chk("done_latency", cyc - c_last, 513);
      @(negedge clk);
      start = 1'b1;
      chk("done_one_cycle", done, 0);
      chk("idle_in_ready", in_ready, 0);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("done_count", done_cnt - d0, v.exp_done);
      chk("idle_after_done_busy", busy, 1);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0,    1'b0, 1'b0, 0,  -1,  N,   1};
    tbl[1] = '{0,    1'b0, 1'b1, 0,  -1,  N,   1};
    tbl[2] = '{0,    1'b0, 1'b0, 50, -1,  N,   1};
    tbl[3] = '{0,    1'b1, 1'b1, 30, -1,  N,   1};
    tbl[4] = '{0,    1'b0, 1'b0, 0,  100, 100, 0};
    tbl[5] = '{1000, 1'b0, 1'b0, 0,  -1,  N,   1};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lane", dout_lane, 0);
    chk("rst_addr", dout_addr, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pre_rst_in_ready", in_ready, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_no_start_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;

    for (int i = 0; i < 6; i++) run_block(tbl[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
